accel_cfg_receiver: RTL and testbench

//  Accelerator-side end of the CPU accelerator bus. Captures the CPU's sequential 16-bit bus_wr/bus_data

---
 rtl/accel_cfg_receiver_if.sv | 25 ++
 rtl/accel_cfg_receiver.sv | 112 +++++++++++
 tb/tb_accel_cfg_receiver.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_cfg_receiver_if.sv
// Purpose: CPU accelerator bus plus core start/done handshake, grouped for the config receiver.
// Latency: wires only, no storage.
// Backpressure: none; the CPU paces writes with accel_en/bus_wr, the core paces completion with core_done.
interface accel_cfg_receiver_if #(
  parameter int DATA_W = 16
);
  logic              accel_en;
  logic              bus_wr;
  logic [DATA_W-1:0] bus_data;
  logic              accel_done;
  logic              core_start;
  logic              core_done;

  // master: the environment around the receiver (CPU issuing writes, core reporting completion)
  modport master (
    output accel_en, bus_wr, bus_data, core_done,
    input  accel_done, core_start
  );

  // slave: the config receiver itself
  modport slave (
    input  accel_en, bus_wr, bus_data, core_done,
    output accel_done, core_start
  );
endinterface

// File: rtl/accel_cfg_receiver.sv
// Purpose: captures a sequential address-less write stream into NUM_REGS config words, then runs one core job.
// Latency: last config write in cycle N -> core_start in N+1; core_done in cycle M -> accel_done from M+1.
// Backpressure: none; writes are accepted whenever accel_en is high, writes during LAUNCH/RUN are dropped and flagged.
module accel_cfg_receiver #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 16,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst_n,
  accel_cfg_receiver_if.slave          bus,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_regs,
  output logic                         busy,
  output logic                         err_overrun,
  output logic                         err_timeout
);

  localparam int              PTR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int              WD_W     = $clog2(WDOG_CYCLES + 2);
  localparam int unsigned     WD_LIM   = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [WD_W-1:0]   wdog;
  logic              wr_acc;
  logic              new_job;
  logic              last_wr;
  logic              wdog_exp;

  assign wr_acc  = bus.bus_wr & bus.accel_en;
  assign new_job = wr_acc & ((state == S_IDLE) | (state == S_DONE));
  assign last_wr = (ptr == PTR_LAST);
  // Expiry is judged on the post-increment count so DONE is entered exactly WDOG_CYCLES cycles after core_start.
  assign wdog_exp = (WDOG_CYCLES != 0) && ((32'(wdog) + 32'd1) >= WD_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: load words, one-cycle launch, run until core_done or watchdog
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (wr_acc) state_nxt = (NUM_REGS == 1) ? S_LAUNCH : S_LOAD;
      S_LOAD:         if (wr_acc && last_wr) state_nxt = S_LAUNCH;
      S_LAUNCH:       state_nxt = S_RUN;
      S_RUN:          if (bus.core_done || wdog_exp) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy is the only combinational output
  always_comb begin
    busy = (state == S_LOAD) | (state == S_LAUNCH) | (state == S_RUN);
  end

  // Datapath: word capture, pointer, watchdog, sticky errors and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_regs       <= '0;
      ptr            <= '0;
      wdog           <= '0;
      err_overrun    <= 1'b0;
      err_timeout    <= 1'b0;
      bus.core_start <= 1'b0;
      bus.accel_done <= 1'b0;
    end else begin
      bus.core_start <= (state_nxt == S_LAUNCH);
      bus.accel_done <= (state_nxt == S_DONE);
      if (new_job) begin
        cfg_regs[DATA_W-1:0] <= bus.bus_data;
        ptr                  <= (NUM_REGS == 1) ? '0 : PTR_W'(1);
        err_overrun          <= 1'b0;
        err_timeout          <= 1'b0;
      end else begin
        unique case (state)
          S_LOAD: begin
            if (wr_acc) begin
              cfg_regs[int'(ptr)*DATA_W +: DATA_W] <= bus.bus_data;
              ptr <= last_wr ? '0 : ptr + PTR_W'(1);
            end
          end
          S_LAUNCH: begin
            wdog <= '0;
            if (wr_acc) err_overrun <= 1'b1;
          end
          S_RUN: begin
            if (wr_acc) err_overrun <= 1'b1;
            // A coincident core_done beats the watchdog, so no error in that case
            if (!bus.core_done) begin
              wdog <= wdog + WD_W'(1);
              if (wdog_exp) err_timeout <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_cfg_receiver.sv
// Purpose: randomized scoreboard bench for accel_cfg_receiver plus a short-watchdog instance for timeout cases.
// Latency: expects core_start one cycle after the last word and accel_done one cycle after core_done.
// Backpressure: none modelled; gaps come from accel_en low and idle bus_wr cycles.
module tb_accel_cfg_receiver;
  localparam int NR = 5;
  localparam int DW = 16;
  localparam int CW = NR * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  accel_cfg_receiver_if #(.DATA_W(DW)) ifa ();
  accel_cfg_receiver_if #(.DATA_W(DW)) ifb ();

  logic [CW-1:0] cfg_a, cfg_b;
  logic busy_a, ovr_a, to_a, busy_b, ovr_b, to_b;

  accel_cfg_receiver #(.NUM_REGS(NR), .DATA_W(DW), .WDOG_CYCLES(4096)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .cfg_regs(cfg_a), .busy(busy_a), .err_overrun(ovr_a), .err_timeout(to_a)
  );

  accel_cfg_receiver #(.NUM_REGS(NR), .DATA_W(DW), .WDOG_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .cfg_regs(cfg_b), .busy(busy_b), .err_overrun(ovr_b), .err_timeout(to_b)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard entries, pushed by the stimulus, popped by the monitor
  typedef struct { int at; logic [CW-1:0] cfg; } start_exp_t;
  typedef struct { int at; logic ovr; logic [CW-1:0] cfg; } done_exp_t;
  start_exp_t start_q[$];
  done_exp_t  done_q[$];

  logic done_prev = 1'b0;

  // Monitor: compares every core_start pulse and accel_done rise against the queues
  always @(negedge clk) begin
    if (ifa.core_start) begin
      if (start_q.size() == 0) begin
        check("spurious_core_start", CW'(ifa.core_start), CW'(0));
      end else begin
        start_exp_t e;
        e = start_q.pop_front();
        check("core_start_cycle", CW'(cyc), CW'(e.at));
        check("cfg_at_start", cfg_a, e.cfg);
      end
    end
    if (ifa.accel_done && !done_prev) begin
      if (done_q.size() == 0) begin
        check("spurious_accel_done", CW'(ifa.accel_done), CW'(0));
      end else begin
        done_exp_t d;
        d = done_q.pop_front();
        check("accel_done_cycle", CW'(cyc), CW'(d.at));
        check("err_overrun_at_done", CW'(ovr_a), CW'(d.ovr));
        check("err_timeout_at_done", CW'(to_a), CW'(0));
        check("cfg_at_done", cfg_a, d.cfg);
      end
    end
    done_prev = ifa.accel_done;
  end

  logic [DW-1:0] jw [NR];
  logic [CW-1:0] cur_cfg;
  int            last_wr_cyc;

  task automatic drv(input logic en, input logic wr, input logic [DW-1:0] d, input logic cd);
    @(posedge clk); #1;
    ifa.accel_en  = en;
    ifa.bus_wr    = wr;
    ifa.bus_data  = d;
    ifa.core_done = cd;
  endtask

  task automatic drv_b(input logic en, input logic wr, input logic [DW-1:0] d);
    @(posedge clk); #1;
    ifb.accel_en  = en;
    ifb.bus_wr    = wr;
    ifb.bus_data  = d;
    ifb.core_done = 1'b0;
  endtask

  // Writes jw[] as one job; gap_len cycles of accel_en low (bus_wr toggling) before word gap_at
  task automatic load_job(input int gap_at, input int gap_len, input bit rnd_gaps);
    for (int i = 0; i < NR; i++) begin
      if (i > 0 && rnd_gaps) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1) drv(1'b0, 1'($urandom_range(0, 1)), DW'($urandom), 1'b0);
          else                           drv(1'b1, 1'b0, DW'($urandom), 1'b0);
        end
      end
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) drv(1'b0, 1'(g % 2 == 0), DW'($urandom), 1'b0);
      end
      drv(1'b1, 1'b1, jw[i], 1'b0);
      if (i == 0) begin
        drv(1'b1, 1'b0, '0, 1'b0);
        check("first_wr_accel_done_low", CW'(ifa.accel_done), CW'(0));
        check("first_wr_cfg0", CW'(cfg_a[DW-1:0]), CW'(jw[0]));
        check("first_wr_busy", CW'(busy_a), CW'(1));
        check("first_wr_ovr_clear", CW'(ovr_a), CW'(0));
        check("first_wr_to_clear", CW'(to_a), CW'(0));
      end
    end
    last_wr_cyc = cyc;
    for (int i = 0; i < NR; i++) cur_cfg[i*DW +: DW] = jw[i];
    start_q.push_back('{at: last_wr_cyc + 1, cfg: cur_cfg});
  endtask

  // core_done dly cycles after core_start; optional stray write at offset ovk (-1 = none)
  task automatic run_job(input int dly, input int ovk, input logic [DW-1:0] ovd);
    int s;
    s = last_wr_cyc + 1;
    done_q.push_back('{at: s + dly + 1, ovr: (ovk >= 0), cfg: cur_cfg});
    for (int k = 0; k <= dly; k++) drv(1'b1, 1'(k == ovk), (k == ovk) ? ovd : DW'(0), 1'(k == dly));
    drv(1'b1, 1'b0, '0, 1'b0);
    repeat (3) drv(1'($urandom_range(0, 1)), 1'b0, '0, 1'b0);
    check("accel_done_held", CW'(ifa.accel_done), CW'(1));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_cfg"}, cfg_a, '0);
    check({tag, "_busy"}, CW'(busy_a), CW'(0));
    check({tag, "_accel_done"}, CW'(ifa.accel_done), CW'(0));
    check({tag, "_core_start"}, CW'(ifa.core_start), CW'(0));
    check({tag, "_errs"}, CW'({ovr_a, to_a}), CW'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    ifa.accel_en = 1'b0; ifa.bus_wr = 1'b0; ifa.bus_data = '0; ifa.core_done = 1'b0;
    #1;
    reset_checks(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) drv(1'b1, 1'b0, '0, 1'b0);
    check({tag, "_busy_after_release"}, CW'(busy_a), CW'(0));
  endtask

  // Short-watchdog job: give_done=0 lets the watchdog fire, 1 asserts core_done on the expiry cycle
  task automatic b_job(input bit give_done);
    int sc, dc, lw;
    sc = -1; dc = -1;
    for (int i = 0; i < NR; i++) begin
      drv_b(1'b1, 1'b1, DW'($urandom));
      if (i == 0) begin
        drv_b(1'b1, 1'b0, '0);
        check("b_first_wr_to_clear", CW'(to_b), CW'(0));
        check("b_first_wr_accel_done_low", CW'(ifb.accel_done), CW'(0));
      end
    end
    lw = cyc;
    for (int k = 0; k < 4 && sc < 0; k++) begin
      drv_b(1'b1, 1'b0, '0);
      if (ifb.core_start) sc = cyc;
    end
    check("b_start_latency", CW'(sc - lw), CW'(1));
    for (int k = 0; k < 40 && dc < 0 && sc >= 0; k++) begin
      @(posedge clk); #1;
      ifb.core_done = give_done && (cyc == sc + 15);
      if (ifb.accel_done) dc = cyc;
    end
    drv_b(1'b1, 1'b0, '0);
    check("b_done_delay", CW'(dc - sc), CW'(16));
    check("b_err_timeout", CW'(to_b), give_done ? CW'(0) : CW'(1));
    check("b_err_overrun", CW'(ovr_b), CW'(0));
    check("b_busy_done", CW'(busy_b), CW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    int dly;
    ifa.accel_en = 1'b0; ifa.bus_wr = 1'b0; ifa.bus_data = '0; ifa.core_done = 1'b0;
    ifb.accel_en = 1'b0; ifb.bus_wr = 1'b0; ifb.bus_data = '0; ifb.core_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst_n = 1'b1;
    repeat (2) drv(1'b1, 1'b0, '0, 1'b0);

    // Back-to-back directed job, core_done 20 cycles after start
    jw[0] = 16'h0010; jw[1] = 16'h0200; jw[2] = 16'h0400; jw[3] = 16'h0008; jw[4] = 16'h0004;
    load_job(-1, 0, 1'b0);
    run_job(20, -1, '0);

    // New job from DONE starting with 0x1111, stray 0xDEAD write during RUN
    jw[0] = 16'h1111; jw[1] = 16'h2222; jw[2] = 16'h3333; jw[3] = 16'h4444; jw[4] = 16'h5555;
    load_job(-1, 0, 1'b0);
    run_job(12, 5, 16'hDEAD);

    // Same words as the first job with a 3-cycle accel_en gap between words 2 and 3
    jw[0] = 16'h0010; jw[1] = 16'h0200; jw[2] = 16'h0400; jw[3] = 16'h0008; jw[4] = 16'h0004;
    load_job(2, 3, 1'b0);
    run_job(7, -1, '0);

    // Overrun write in the LAUNCH cycle and coincident with core_done
    for (int i = 0; i < NR; i++) jw[i] = DW'($urandom);
    load_job(-1, 0, 1'b1);
    run_job(4, 0, DW'($urandom));
    for (int i = 0; i < NR; i++) jw[i] = DW'($urandom);
    load_job(-1, 0, 1'b1);
    run_job(6, 6, DW'($urandom));

    // Randomized jobs
    for (int j = 0; j < 10; j++) begin
      for (int i = 0; i < NR; i++) jw[i] = DW'($urandom);
      load_job(-1, 0, 1'b1);
      dly = $urandom_range(1, 30);
      run_job(dly, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, dly)) : -1, DW'($urandom));
    end

    // Reset after the third write of a job: no start afterwards
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b1, DW'($urandom), 1'b0);
    @(posedge clk); #1;
    do_reset("rst_mid_load");

    // Reset during RUN: no accel_done afterwards
    for (int i = 0; i < NR; i++) jw[i] = DW'($urandom);
    load_job(-1, 0, 1'b0);
    repeat (6) drv(1'b1, 1'b0, '0, 1'b0);
    do_reset("rst_mid_run");

    // Pointer restarted at word 0 after the aborts
    for (int i = 0; i < NR; i++) jw[i] = DW'($urandom);
    load_job(-1, 0, 1'b0);
    run_job(9, -1, '0);

    // Short-watchdog instance: timeout, then core_done on the expiry cycle
    b_job(1'b0);
    b_job(1'b1);

    repeat (3) drv(1'b0, 1'b0, '0, 1'b0);
    check("start_q_drained", CW'(start_q.size()), CW'(0));
    check("done_q_drained", CW'(done_q.size()), CW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
